// File: rtl/sensor_cond_pkg.sv
// Shared constants and types for the sensor conditioning front end.
// Default debounce window is 10 ms of the 50 MHz system clock.
package sensor_cond_pkg;

  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned CHATTER_LIMIT_DEFAULT   = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

  // Per-channel status handed from a debounce channel to the top level.
  typedef struct packed {
    logic clean;       // debounced level
    logic pulse;       // one-cycle pulse, registered with the clean update
    logic primed_nxt;  // primed flag as it will be after this edge
    logic fault;       // sticky chatter fault
  } chan_status_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter, priming,
// clean level with change pulse, and optional chatter fault.
// Optional feature macro: SENSOR_CHATTER_DETECT_EN (restart counter + fault).
module debounce_channel
  import sensor_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CHATTER_LIMIT   = CHATTER_LIMIT_DEFAULT
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         raw_i,
  output chan_status_t status_o
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  // fill_q marks which pipeline positions hold real post-reset samples; the
  // counter is held in restart until prev does, so a reset-value 0 can never
  // prime the channel early.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   primed_q, primed_d;
  logic                   pulse_q, pulse_d;
  logic                   s;
  logic                   changed;
  logic                   restart;
  logic                   qualify;
  logic                   fault;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state for the stability counter and the qualified level.
  always_comb begin
    changed  = (s != prev_q);
    restart  = changed | ~fill_q[SYNC_STAGES];
    qualify  = ~restart & (cnt_q == CNT_MAX);
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    primed_d = primed_q;
    pulse_d  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (qualify) begin
      if (!primed_q) begin
        clean_d  = s;
        primed_d = 1'b1;
      end else if (s != clean_q) begin
        clean_d = s;
        pulse_d = 1'b1;
      end
    end
  end

  // Synchroniser, sample history and debounce state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      fill_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      primed_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q   <= s;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      primed_q <= primed_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef SENSOR_CHATTER_DETECT_EN
  localparam int unsigned     RC_W   = cnt_width(CHATTER_LIMIT);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(CHATTER_LIMIT);

  logic [RC_W-1:0] rc_q, rc_d;
  logic            fault_q;

  // Restarts since the last qualification, saturating at the limit.
  always_comb begin
    rc_d = rc_q;
    if (qualify) begin
      rc_d = '0;
    end else if (changed && (rc_q != RC_MAX)) begin
      rc_d = rc_q + RC_W'(1);
    end
  end

  // Restart counter and sticky fault; the fault never gates debouncing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      rc_q <= rc_d;
      if (rc_d == RC_MAX) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault = fault_q;
`else
  // Chatter detection not built: fault is a constant 0 for any limit value.
  assign fault = 1'b0 & (CHATTER_LIMIT == 0);
`endif

  assign status_o = '{clean: clean_q, pulse: pulse_q, primed_nxt: primed_d, fault: fault};

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor conditioner top: two independent debounce channels (rain, soil-dry)
// feeding clean levels, edge pulses, a combined valid flag and fault flags.
// Optional feature macro: SENSOR_CHATTER_DETECT_EN (chatter faults).
module sensor_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CHATTER_LIMIT   = CHATTER_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic rain_in,
  input  logic soil_sensor_digital,
  output logic rain_clean,
  output logic soil_dry_clean,
  output logic rain_rise,
  output logic rain_fall,
  output logic soil_change,
  output logic inputs_valid,
  output logic rain_fault,
  output logic soil_fault
);

  chan_status_t rain_st;
  chan_status_t soil_st;
  logic         valid_q;

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CHATTER_LIMIT   (CHATTER_LIMIT)
  ) u_rain (
    .clk_i    (clk),
    .reset_i  (reset),
    .raw_i    (rain_in),
    .status_o (rain_st)
  );

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CHATTER_LIMIT   (CHATTER_LIMIT)
  ) u_soil (
    .clk_i    (clk),
    .reset_i  (reset),
    .raw_i    (soil_sensor_digital),
    .status_o (soil_st)
  );

  // Valid rises on the same edge the second channel primes; it is sticky
  // because primed flags only clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= rain_st.primed_nxt & soil_st.primed_nxt;
    end
  end

  // The channel pulse is registered alongside the new clean level, so the
  // level tells the direction.
  assign rain_clean     = rain_st.clean;
  assign soil_dry_clean = soil_st.clean;
  assign rain_rise      = rain_st.pulse & rain_st.clean;
  assign rain_fall      = rain_st.pulse & ~rain_st.clean;
  assign soil_change    = soil_st.pulse;
  assign inputs_valid   = valid_q;
  assign rain_fault     = rain_st.fault;
  assign soil_fault     = soil_st.fault;

endmodule
